// File: rtl/spike_rx_interface.sv
// Receive-side network interface: buffers router spike packets and
// delivers one weighted spike per handshake to the neuron array.
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   rx_valid         router offers rx_packet
//   rx_packet        {src[31:24], idx[23:16], weight[15:0]}
//   rx_ready         FIFO can accept (not full)
//   nrn_valid        spike offered to the neuron array
//   nrn_sel          one-hot target neuron, zero when idle
//   nrn_weight       signed weight, passed through unmodified
//   nrn_src          source node id
//   nrn_ready        neuron array accepts the spike
//   drop_pulse       one cycle per discarded bad-index packet
//   busy             FIFO holds data or FSM is not idle
//   rx_count         accepted packets (SPIKE_RX_STATS_EN only)
//   drop_count       dropped packets (SPIKE_RX_STATS_EN only)
//
// Optional feature macro: SPIKE_RX_STATS_EN enables the saturating
// rx_count/drop_count counters and their ports.
module spike_rx_interface #(
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_NEURONS = 4,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rx_valid,
  input  logic [DATA_WIDTH-1:0]  rx_packet,
  output logic                   rx_ready,
  output logic                   nrn_valid,
  output logic [NUM_NEURONS-1:0] nrn_sel,
  output logic [15:0]            nrn_weight,
  output logic [7:0]             nrn_src,
  input  logic                   nrn_ready,
  output logic                   drop_pulse,
  output logic                   busy
`ifdef SPIKE_RX_STATS_EN
  ,
  output logic [15:0]            rx_count,
  output logic [15:0]            drop_count
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [7:0] BCAST_IDX = 8'hFF;
  localparam logic [7:0] NN8 = 8'(NUM_NEURONS);
  localparam logic [7:0] LAST = 8'(NUM_NEURONS - 1);
  localparam logic [NUM_NEURONS-1:0] ONE = NUM_NEURONS'(1);

  typedef enum logic [1:0] {
    IDLE,
    DECODE,
    UNI,
    BCAST
  } state_t;

  state_t state_q, state_d;

  // ---------------- ingress FIFO ----------------
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW:0] wp, rp;
  logic empty, full, push, pop;

  // Extra pointer bit separates full from empty.
  assign empty = (wp == rp);
  assign full  = (wp[AW] != rp[AW]) &&
                 (wp[AW-1:0] == rp[AW-1:0]);

  // No push-through: a pop in the same cycle
  // does not reopen a full FIFO.
  assign rx_ready = !full;
  assign push = rx_valid && !full;
  assign pop  = (state_q == IDLE) && !empty;

  always_ff @(posedge clk) begin
    if (push)
      mem[wp[AW-1:0]] <= rx_packet;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
    end
  end

  // ---------------- hold register ----------------
  logic [DATA_WIDTH-1:0] hold;
  logic [7:0]  h_src, h_idx;
  logic [15:0] h_w;

  always_ff @(posedge clk) begin
    if (rst)
      hold <= '0;
    else if (pop)
      hold <= mem[rp[AW-1:0]];
  end

  assign h_src = hold[31:24];
  assign h_idx = hold[23:16];
  assign h_w   = hold[15:0];

  // ---------------- FSM: state register ----------------
  logic [7:0] cnt_q, cnt_d;
  logic       cnt_last;

  assign cnt_last = (cnt_q == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (!empty) state_d = DECODE;
      end
      DECODE: begin
        unique case (1'b1)
          (h_idx == BCAST_IDX): begin
            state_d = BCAST;
            cnt_d   = '0;
          end
          (h_idx < NN8): state_d = UNI;
          default:       state_d = IDLE;
        endcase
      end
      UNI: begin
        if (nrn_ready) state_d = IDLE;
      end
      BCAST: begin
        if (nrn_ready) begin
          if (cnt_last) state_d = IDLE;
          else          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------- FSM: outputs (next values) ----------------
  // Outputs are computed one cycle ahead and registered, so
  // they are presented the cycle after DECODE and hold steady
  // until the neuron array accepts.
  logic                   valid_d, drop_d;
  logic [NUM_NEURONS-1:0] sel_d;
  logic [15:0]            weight_d;
  logic [7:0]             src_d;

  always_comb begin
    valid_d  = nrn_valid;
    sel_d    = nrn_sel;
    weight_d = nrn_weight;
    src_d    = nrn_src;
    drop_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        valid_d = 1'b0;
        sel_d   = '0;
      end
      DECODE: begin
        unique case (1'b1)
          (h_idx == BCAST_IDX): begin
            valid_d  = 1'b1;
            sel_d    = ONE;
            weight_d = h_w;
            src_d    = h_src;
          end
          (h_idx < NN8): begin
            valid_d  = 1'b1;
            sel_d    = ONE << h_idx;
            weight_d = h_w;
            src_d    = h_src;
          end
          default: begin
            valid_d = 1'b0;
            sel_d   = '0;
            drop_d  = 1'b1;
          end
        endcase
      end
      UNI: begin
        if (nrn_ready) begin
          valid_d = 1'b0;
          sel_d   = '0;
        end
      end
      BCAST: begin
        if (nrn_ready) begin
          if (cnt_last) begin
            valid_d = 1'b0;
            sel_d   = '0;
          end else begin
            sel_d = ONE << (cnt_q + 8'd1);
          end
        end
      end
      default: begin
        valid_d = 1'b0;
        sel_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      nrn_valid  <= 1'b0;
      nrn_sel    <= '0;
      nrn_weight <= '0;
      nrn_src    <= '0;
      drop_pulse <= 1'b0;
    end else begin
      nrn_valid  <= valid_d;
      nrn_sel    <= sel_d;
      nrn_weight <= weight_d;
      nrn_src    <= src_d;
      drop_pulse <= drop_d;
    end
  end

  assign busy = !empty || (state_q != IDLE);

`ifdef SPIKE_RX_STATS_EN
  // ---------------- saturating statistics ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_count   <= '0;
      drop_count <= '0;
    end else begin
      if (push && rx_count != 16'hFFFF)
        rx_count <= rx_count + 16'd1;
      if (drop_d && drop_count != 16'hFFFF)
        drop_count <= drop_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_spike_rx_interface.sv
// Directed bench for spike_rx_interface with a delivery scoreboard.
// Expected spikes are queued at ingress and checked on handshake.
module tb_spike_rx_interface;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_valid;
  logic [31:0] rx_packet;
  logic        rx_ready;
  logic        nrn_valid;
  logic [3:0]  nrn_sel;
  logic [15:0] nrn_weight;
  logic [7:0]  nrn_src;
  logic        nrn_ready;
  logic        drop_pulse;
  logic        busy;
`ifdef SPIKE_RX_STATS_EN
  logic [15:0] rx_count;
  logic [15:0] drop_count;
`endif

  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    logic [3:0]  sel;
    logic [15:0] w;
    logic [7:0]  src;
  } exp_t;

  exp_t sb[$];

  spike_rx_interface #(
    .DATA_WIDTH(32),
    .NUM_NEURONS(4),
    .FIFO_DEPTH(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rx_valid(rx_valid),
    .rx_packet(rx_packet),
    .rx_ready(rx_ready),
    .nrn_valid(nrn_valid),
    .nrn_sel(nrn_sel),
    .nrn_weight(nrn_weight),
    .nrn_src(nrn_src),
    .nrn_ready(nrn_ready),
    .drop_pulse(drop_pulse),
    .busy(busy)
`ifdef SPIKE_RX_STATS_EN
    ,
    .rx_count(rx_count),
    .drop_count(drop_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  // Drive one packet; returns at posedge+1 of the
  // accepting edge and records the expected spikes.
  task automatic send(input logic [31:0] p);
    int n;
    logic [7:0] idx;
    exp_t e;
    n = 0;
    rx_valid = 1'b1;
    rx_packet = p;
    @(negedge clk);
    while (!rx_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    check("rx_accept", {31'd0, rx_ready}, 32'd1);
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    idx = p[23:16];
    e.w = p[15:0];
    e.src = p[31:24];
    if (idx == 8'hFF) begin
      for (int i = 0; i < 4; i++) begin
        e.sel = 4'b0001 << i;
        sb.push_back(e);
      end
    end else if (idx < 8'd4) begin
      e.sel = 4'b0001 << idx[1:0];
      sb.push_back(e);
    end
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (!rst) begin
      if (nrn_valid && nrn_ready) begin
        check("delivery_expected",
              {31'd0, sb.size() != 0}, 32'd1);
        if (sb.size() != 0) begin
          exp_t e;
          e = sb.pop_front();
          check("sb_sel", {28'd0, nrn_sel}, {28'd0, e.sel});
          check("sb_weight", {16'd0, nrn_weight}, {16'd0, e.w});
          check("sb_src", {24'd0, nrn_src}, {24'd0, e.src});
        end
      end
      if (!nrn_valid)
        check("sel_zero_idle", {28'd0, nrn_sel}, 32'd0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1;
    rx_valid = 1'b0;
    rx_packet = '0;
    nrn_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // 1: reset state
    @(negedge clk);
    check("rst_rx_ready", {31'd0, rx_ready}, 32'd1);
    check("rst_valid", {31'd0, nrn_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_weight", {16'd0, nrn_weight}, 32'd0);
    check("rst_src", {24'd0, nrn_src}, 32'd0);
    check("rst_drop", {31'd0, drop_pulse}, 32'd0);
`ifdef SPIKE_RX_STATS_EN
    check("rst_rx_count", {16'd0, rx_count}, 32'd0);
    check("rst_drop_count", {16'd0, drop_count}, 32'd0);
`endif
    @(posedge clk);
    #1;

    // 2: unicast latency and single-cycle valid
    nrn_ready = 1'b1;
    send(32'h0302_0005);
    @(negedge clk);
    check("uni_t1_valid", {31'd0, nrn_valid}, 32'd0);
    check("uni_t1_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    check("uni_t2_valid", {31'd0, nrn_valid}, 32'd0);
    @(negedge clk);
    check("uni_t3_valid", {31'd0, nrn_valid}, 32'd1);
    check("uni_t3_sel", {28'd0, nrn_sel}, 32'h4);
    check("uni_t3_weight", {16'd0, nrn_weight}, 32'h5);
    check("uni_t3_src", {24'd0, nrn_src}, 32'h3);
    @(negedge clk);
    check("uni_t4_valid", {31'd0, nrn_valid}, 32'd0);
    @(posedge clk);
    #1;

    // 3: broadcast walk
    send(32'h01FF_FFFE);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("bc_valid", {31'd0, nrn_valid}, 32'd1);
      check("bc_sel", {28'd0, nrn_sel}, 32'd1 << i);
      check("bc_weight", {16'd0, nrn_weight}, 32'hFFFE);
    end
    @(negedge clk);
    check("bc_done_valid", {31'd0, nrn_valid}, 32'd0);
    check("bc_done_busy", {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1;

    // 4: bad index is dropped
    send(32'h0207_1234);
    repeat (2) @(negedge clk);
    check("drop_t2", {31'd0, drop_pulse}, 32'd0);
    @(negedge clk);
    check("drop_t3_pulse", {31'd0, drop_pulse}, 32'd1);
    check("drop_t3_valid", {31'd0, nrn_valid}, 32'd0);
    @(negedge clk);
    check("drop_t4_pulse", {31'd0, drop_pulse}, 32'd0);
    check("drop_t4_valid", {31'd0, nrn_valid}, 32'd0);
`ifdef SPIKE_RX_STATS_EN
    check("drop_count", {16'd0, drop_count}, 32'd1);
`endif
    @(posedge clk);
    #1;

    // 5: back-pressure fills FIFO plus hold
    nrn_ready = 1'b0;
    send(32'h1000_0101);
    send(32'h1101_0202);
    send(32'h1202_0303);
    send(32'h1303_0404);
    send(32'h1401_8005);
    rx_valid = 1'b1;
    rx_packet = 32'h1500_0606;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("full_rx_ready", {31'd0, rx_ready}, 32'd0);
      check("full_hold_sel", {28'd0, nrn_sel}, 32'h1);
      check("full_hold_w", {16'd0, nrn_weight}, 32'h0101);
    end
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
`ifdef SPIKE_RX_STATS_EN
    check("rx_count", {16'd0, rx_count}, 32'd8);
`endif
    nrn_ready = 1'b1;
    n = 0;
    @(negedge clk);
    while ((sb.size() != 0 || busy) && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("drain_sb_left", sb.size(), 32'd0);
    check("drain_busy", {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1;

    // 6: reset in the middle of a broadcast
    send(32'h05FF_0042);
    send(32'h0601_0011);
    n = 0;
    @(negedge clk);
    while (nrn_sel != 4'b0010 && n < 20) begin
      n++;
      @(negedge clk);
    end
    check("bc6_reach_cnt1", {28'd0, nrn_sel}, 32'h2);
    @(posedge clk);
    #1;
    rst = 1'b1;
    nrn_ready = 1'b0;
    @(negedge clk);
    check("bc6_cnt2_sel", {28'd0, nrn_sel}, 32'h4);
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    @(negedge clk);
    check("rst6_valid", {31'd0, nrn_valid}, 32'd0);
    check("rst6_sel", {28'd0, nrn_sel}, 32'd0);
    check("rst6_busy", {31'd0, busy}, 32'd0);
    check("rst6_rx_ready", {31'd0, rx_ready}, 32'd1);
    nrn_ready = 1'b1;
    repeat (12) @(negedge clk);
    check("rst6_still_idle", {31'd0, busy}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
